// File: rtl/sm_transition_monitor_if.sv
// ---------------------------------------------------------------------------
// sm_transition_monitor_if
//   Bundle between the state generator side (master) and the passive
//   transition monitor (slave).
//   Signals:
//     state, old_state   generator -> monitor, current / previous state
//     trans_err          illegal arc seen in the sampled pair
//     range_err          a sampled state was above 10
//     hist_err           old_state disagreed with the state sampled last edge
//     err_count          saturating count of cycles with any error flag
//     check_count        saturating count of checked pairs
//     arc_hit            sticky bitmap of legal arcs observed
//     arc_cov            number of bits set in arc_hit
// ---------------------------------------------------------------------------
interface sm_transition_monitor_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       state;
    logic [3:0]       old_state;
    logic             trans_err;
    logic             range_err;
    logic             hist_err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] check_count;
    logic [17:0]      arc_hit;
    logic [4:0]       arc_cov;

    modport master (
        output state, old_state,
        input  trans_err, range_err, hist_err, err_count, check_count,
               arc_hit, arc_cov
    );

    modport slave (
        input  state, old_state,
        output trans_err, range_err, hist_err, err_count, check_count,
               arc_hit, arc_cov
    );
endinterface

// File: rtl/sm_transition_monitor.sv
// ---------------------------------------------------------------------------
// sm_transition_monitor
//   Passive checker for the 11-state (0..10) test state machine. On every
//   rising clk it samples (old_state -> state), flags illegal arcs,
//   out-of-range states and broken history, keeps saturating error / check
//   counters and a sticky coverage bitmap of the legal arcs seen.
//   Ports:
//     clk   in  rising-edge clock
//     rst   in  asynchronous active-low reset
//     bus   slave modport of sm_transition_monitor_if (inputs state /
//           old_state, all checker results are outputs)
// ---------------------------------------------------------------------------
module sm_transition_monitor #(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    sm_transition_monitor_if.slave  bus
);

    logic [3:0]       r_prev;
    logic             r_armed;
    logic             r_trans_err;
    logic             r_range_err;
    logic             r_hist_err;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_check_count;
    logic [17:0]      r_arc_hit;

    logic             w_arc_ok;
    logic [4:0]       w_arc_idx;
    logic             w_recov;
    logic             w_trans_err;
    logic             w_range_err;
    logic             w_hist_err;
    logic [4:0]       w_arc_cov;

    // Legal-arc decode: {old,new} -> coverage bit index.
    always_comb begin
        w_arc_ok  = 1'b1;
        w_arc_idx = 5'd0;
        case ({bus.old_state, bus.state})
            8'h01: w_arc_idx = 5'd0;
            8'h12: w_arc_idx = 5'd1;
            8'h14: w_arc_idx = 5'd2;
            8'h23: w_arc_idx = 5'd3;
            8'h31: w_arc_idx = 5'd4;
            8'h35: w_arc_idx = 5'd5;
            8'h45: w_arc_idx = 5'd6;
            8'h51: w_arc_idx = 5'd7;
            8'h56: w_arc_idx = 5'd8;
            8'h67: w_arc_idx = 5'd9;
            8'h70: w_arc_idx = 5'd10;
            8'h78: w_arc_idx = 5'd11;
            8'h82: w_arc_idx = 5'd12;
            8'h84: w_arc_idx = 5'd13;
            8'h89: w_arc_idx = 5'd14;
            8'h8A: w_arc_idx = 5'd15;
            8'h90: w_arc_idx = 5'd16;
            8'hA0: w_arc_idx = 5'd17;
            default: w_arc_ok = 1'b0;
        endcase
    end

    // Out-of-range old state jumping to 4 is the generator's recovery path:
    // not a transition error, but still reported by range_err.
    assign w_recov     = (bus.old_state > 4'd10) && (bus.state == 4'd4);
    assign w_trans_err = !(w_arc_ok || w_recov);
    assign w_range_err = (bus.state > 4'd10) || (bus.old_state > 4'd10);
    assign w_hist_err  = (bus.old_state != r_prev);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev        <= '0;
            r_armed       <= 1'b0;
            r_trans_err   <= 1'b0;
            r_range_err   <= 1'b0;
            r_hist_err    <= 1'b0;
            r_err_count   <= '0;
            r_check_count <= '0;
            r_arc_hit     <= '0;
        end else if (!r_armed) begin
            // First edge only seeds history; nothing is judged yet.
            r_prev      <= bus.state;
            r_armed     <= 1'b1;
            r_trans_err <= 1'b0;
            r_range_err <= 1'b0;
            r_hist_err  <= 1'b0;
        end else begin
            r_prev      <= bus.state;
            r_trans_err <= w_trans_err;
            r_range_err <= w_range_err;
            r_hist_err  <= w_hist_err;
            if (r_check_count != {CNT_W{1'b1}})
                r_check_count <= r_check_count + 1'b1;
            if ((w_trans_err || w_range_err || w_hist_err) &&
                (r_err_count != {CNT_W{1'b1}}))
                r_err_count <= r_err_count + 1'b1;
            if (w_arc_ok)
                r_arc_hit[w_arc_idx] <= 1'b1;
        end
    end

    always_comb begin
        w_arc_cov = '0;
        for (int i = 0; i < 18; i++)
            w_arc_cov = w_arc_cov + {4'd0, r_arc_hit[i]};
    end

    assign bus.trans_err   = r_trans_err;
    assign bus.range_err   = r_range_err;
    assign bus.hist_err    = r_hist_err;
    assign bus.err_count   = r_err_count;
    assign bus.check_count = r_check_count;
    assign bus.arc_hit     = r_arc_hit;
    assign bus.arc_cov     = w_arc_cov;

endmodule

// File: tb/tb_sm_transition_monitor.sv
// ---------------------------------------------------------------------------
// tb_sm_transition_monitor
//   Two monitors share clk/rst and stimulus: one with 16-bit counters and one
//   with 2-bit counters so saturation is reached quickly. A reference model
//   built from the arc table predicts every output.
// ---------------------------------------------------------------------------
module tb_sm_transition_monitor;

    logic clk = 1'b0;
    logic rst = 1'b0;

    sm_transition_monitor_if #(.CNT_W(16)) bus_a ();
    sm_transition_monitor_if #(.CNT_W(2))  bus_b ();

    sm_transition_monitor #(.CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    sm_transition_monitor #(.CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int arc_from [18] = '{0,1,1,2,3,3,4,5,5,6,7,7,8,8,8,8,9,10};
    int arc_to   [18] = '{1,2,4,3,1,5,5,1,6,7,0,8,2,4,9,10,0,0};

    // reference model state
    bit        m_armed;
    int        m_prev;
    bit        m_trans, m_range, m_hist;
    int        m_chk, m_err;
    bit [17:0] m_hit;
    int        cur;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_prev = 0; m_trans = 0; m_range = 0; m_hist = 0;
        m_chk = 0; m_err = 0; m_hit = '0;
    endtask

    task automatic model_step(input int o, input int s);
        int idx;
        bit recov;
        if (!m_armed) begin
            m_armed = 1; m_prev = s;
            m_trans = 0; m_range = 0; m_hist = 0;
        end else begin
            idx = -1;
            for (int i = 0; i < 18; i++)
                if (arc_from[i] == o && arc_to[i] == s) idx = i;
            recov   = (o > 10) && (s == 4);
            m_trans = (idx < 0) && !recov;
            m_range = (s > 10) || (o > 10);
            m_hist  = (o != m_prev);
            m_prev  = s;
            m_chk++;
            if (m_trans || m_range || m_hist) m_err++;
            if (idx >= 0) m_hit[idx] = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/a.trans"}, 32'(bus_a.trans_err),   32'(m_trans));
        chk({tag, "/a.range"}, 32'(bus_a.range_err),   32'(m_range));
        chk({tag, "/a.hist"},  32'(bus_a.hist_err),    32'(m_hist));
        chk({tag, "/a.err"},   32'(bus_a.err_count),   sat(m_err, 65535));
        chk({tag, "/a.chk"},   32'(bus_a.check_count), sat(m_chk, 65535));
        chk({tag, "/a.hit"},   32'(bus_a.arc_hit),     32'(m_hit));
        chk({tag, "/a.cov"},   32'(bus_a.arc_cov),     $countones(m_hit));
        chk({tag, "/b.trans"}, 32'(bus_b.trans_err),   32'(m_trans));
        chk({tag, "/b.err"},   32'(bus_b.err_count),   sat(m_err, 3));
        chk({tag, "/b.chk"},   32'(bus_b.check_count), sat(m_chk, 3));
        chk({tag, "/b.hit"},   32'(bus_b.arc_hit),     32'(m_hit));
    endtask

    // Called at a falling edge: drive pair, let one rising edge pass, check.
    task automatic step(input int o, input int s, input string tag);
        bus_a.old_state = 4'(o); bus_a.state = 4'(s);
        bus_b.old_state = 4'(o); bus_b.state = 4'(s);
        @(posedge clk);
        model_step(o, s);
        cur = s;
        @(negedge clk);
        check_all(tag);
    endtask

    // Async reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        bus_a.state = 4'($urandom_range(0, 15)); bus_a.old_state = 4'($urandom_range(0, 15));
        bus_b.state = bus_a.state;              bus_b.old_state = bus_a.old_state;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        check_all({tag, "_hold"});
        rst = 1'b1;
    endtask

    task automatic rand_step();
        int o, s, n, pick;
        int succ [$];
        if ($urandom_range(0, 9) < 8) begin
            o = cur;
            succ.delete();
            for (int i = 0; i < 18; i++)
                if (arc_from[i] == cur) succ.push_back(arc_to[i]);
            if (cur > 10) s = 4;
            else begin
                n    = succ.size();
                pick = $urandom_range(0, n - 1);
                s    = succ[pick];
            end
        end else begin
            o = $urandom_range(0, 15);
            s = $urandom_range(0, 15);
        end
        step(o, s, "rand");
    endtask

    int walk [10] = '{0,1,2,3,5,6,7,8,9,0};

    initial begin
        bus_a.state = '0; bus_a.old_state = '0;
        bus_b.state = '0; bus_b.old_state = '0;
        model_reset();
        cur = 0;

        // reset state, then arming edge with 0->1
        do_reset("reset");
        step(0, 1, "arm");
        chk("arm_chk0", 32'(bus_a.check_count), 0);

        // legal walk from a fresh arm at state 0
        do_reset("reset2");
        step(0, 0, "arm2");
        for (int i = 1; i < 10; i++) step(walk[i-1], walk[i], "walk");
        chk("walk_chk9",  32'(bus_a.check_count), 9);
        chk("walk_cov9",  32'(bus_a.arc_cov),     9);
        chk("walk_hit",   32'(bus_a.arc_hit),     32'h14B2B);
        chk("walk_err0",  32'(bus_a.err_count),   0);

        // bugged step 2->4
        step(2, 4, "bug");
        chk("bug_trans", 32'(bus_a.trans_err), 1);
        chk("bug_err1",  32'(bus_a.err_count), 1);
        chk("bug_hit",   32'(bus_a.arc_hit),   32'h14B2B);

        // range: 10->11 then recovery 11->4
        step(10, 11, "rng1");
        chk("rng1_range", 32'(bus_a.range_err), 1);
        chk("rng1_trans", 32'(bus_a.trans_err), 1);
        step(11, 4, "rng2");
        chk("rng2_range", 32'(bus_a.range_err), 1);
        chk("rng2_trans", 32'(bus_a.trans_err), 0);
        chk("rng2_hist",  32'(bus_a.hist_err),  0);
        chk("rng_err3",   32'(bus_a.err_count), 3);

        // history: prev=5, present 3->5
        step(4, 5, "h_pre");
        step(3, 5, "hist");
        chk("hist_flag",  32'(bus_a.hist_err),  1);
        chk("hist_trans", 32'(bus_a.trans_err), 0);
        chk("sat_err_b",  32'(bus_b.err_count), 3);

        // randomized run
        for (int i = 0; i < 400; i++) rand_step();

        // one more error with the narrow counter already saturated
        step(7, 7, "selfloop");
        chk("sat_err_b2", 32'(bus_b.err_count), 3);
        chk("sat_chk_b",  32'(bus_b.check_count), 3);

        // mid-run reset and re-arm
        do_reset("midreset");
        step(5, 5, "rearm");
        for (int i = 0; i < 100; i++) rand_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
